queue_lcu: RTL and testbench
============================

Name: queue_lcu

Overview:
- List control unit for the lab FIFO queue. It sits directly upstream of the 32x32 register file and drives its write port (wa/wd/we) and one read port (ra).
- Turns rising edges on enq/deq requests into circular-buffer writes and reads.
- Tracks head, tail and count, and presents the dequeued word, full/empty flags and per-entry valid bits to the display logic.

Parameters:
- DEPTH, 8, number of queue entries; a power of two, 2..32.
- DW, 32, data width; matches the RF word.
- AW, 5, RF address width; pointers are zero-extended to AW.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- enq  in  1  enqueue request, level; acts on its rising edge. Synchronous to clk.
- deq  in  1  dequeue request, level; acts on its rising edge. Synchronous to clk.
- in  in  DW  data to enqueue; sampled on the cycle the enq edge is accepted.
- out  out  DW  last dequeued word, registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- valid  out  DEPTH  bit i set while entry i holds queued data.
- ra  out  AW  RF read address, combinational = head.
- rd  in  DW  RF read data for ra; combinational read.
- wa  out  AW  RF write address, registered.
- wd  out  DW  RF write data, registered.
- we  out  1  RF write enable, registered, one-cycle pulse.

Behaviour:
- Reset (async, rstn=0):
  - head=tail=0, count=0, out=0, we=0, wa=0, wd=0, valid=0.
  - Hence empty=1, full=0.
  - Edge-detect registers enq_r and deq_r reset to 1, so a request held through reset release is not seen as an edge.
- Edge detect:
  - enq_r and deq_r sample enq and deq every cycle.
  - enq_p = enq & ~enq_r; deq_p = deq & ~deq_r.
  - Each held high produces exactly one pulse.
- Acceptance:
  - acc_enq = enq_p & (~full | acc_deq).
  - acc_deq = deq_p & ~empty.
- Enqueue (at the edge where acc_enq=1):
  - we<=1, wa<=tail, wd<=in.
  - tail<=tail+1 mod DEPTH; valid[tail]<=1.
  - The RF commits the write one edge later. Latency: request edge to RF write is 1 cycle.
- Dequeue (at the edge where acc_deq=1):
  - out<=rd, or the bypass value below.
  - head<=head+1 mod DEPTH; valid[head]<=0.
  - out updates at the same edge the request is accepted.
- Bypass: if we=1 and wa==head while acc_deq=1, the RF has not committed yet, so out<=wd. This case is an enqueue into an empty queue followed by a dequeue on the next cycle.
- we deasserts the cycle after any pulse unless another enqueue is accepted.
- count:
  - +1 on enqueue only; -1 on dequeue only.
  - Unchanged when both are accepted at the same edge, or when neither is.
- Simultaneous enq_p and deq_p:
  - Not empty: both are performed in the same cycle.
  - Full: both are performed; the read sees the old data at head before the write commits.
  - Empty: deq is ignored and enq is performed; out is unchanged.
- Boundary conditions:
  - enq_p while full (no deq): ignored. No we pulse; pointers, valid and out unchanged.
  - deq_p while empty: ignored; out holds its previous value.
- Wrap-around: pointers wrap DEPTH-1 -> 0. The upper AW-log2(DEPTH) address bits are always 0.
- Reset mid-operation clears all state immediately. A we pulse in flight is dropped.
- State machine (per request, encoded in the registered we):
  - IDLE -> WRITE on acc_enq.
  - WRITE -> IDLE, or back to WRITE on a new acc_enq.
  - Dequeue completes within a single cycle from either state.

Decomposition:
- Shared package holds:
  - default DEPTH/DW/AW;
  - PTR_W = clog2(DEPTH);
  - a constant for the RF address width, shared with the RF and the display unit.
- One natural sub-module: edge_pulse (registered sampler plus rising-edge pulse, reset value 1), instantiated twice for enq and deq.

Test Plan:
- Reset, then enq pulse with in=0x11 -> next cycle we=1, wa=0, wd=0x11; then empty=0, valid=8'b0000_0001.
- Enqueue 8 words 0x01..0x08, then a further enq with in=0xFF -> full=1; no we pulse on the ninth request; valid=8'hFF, tail=0.
- From full: deq 8 times -> out follows 0x01..0x08; a ninth deq leaves out=0x08 with empty=1.
- Wrap-around: enq 6, deq 6, enq 4 words 0xA0..0xA3 -> wa sequence 6,7,0,1; then deq returns 0xA0..0xA3 in order.
- Bypass: on an empty queue, enq 0x5A, then raise deq exactly 1 cycle after enq -> out=0x5A; queue ends empty.
- Simultaneous when full with 0x01..0x08: enq=0x99 and deq rise together -> out=0x01, wa=0 (old head slot), full stays 1; draining then yields 0x02..0x08, 0x99.

Source files
------------

// File: rtl/queue_lcu_pkg.sv
// Shared constants and types for the lab FIFO list control unit.
package queue_lcu_pkg;

    // Default queue geometry; the RF word and address width are shared
    // with the register file and the display unit.
    localparam int DEF_DEPTH = 8;
    localparam int DEF_DW    = 32;
    localparam int RF_AW     = 5;
    localparam int DEF_AW    = RF_AW;
    localparam int DEF_PTR_W = $clog2(DEF_DEPTH);

    // Write-side state.  WRITE means a write to the RF is in flight this
    // cycle, so it is exactly the registered write enable.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } lcu_state_e;

endpackage

// File: rtl/queue_lcu_edge_pulse.sv
// Registered sampler plus rising-edge pulse.  The sampler resets to 1 so a
// request held high through reset release does not count as an edge.
module edge_pulse (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic pulse_o
);

    logic d_q;

    // Sample the request level every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d_i;
        end
    end

    assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/queue_lcu.sv
// List control unit: turns enq/deq request edges into circular-buffer
// writes and reads on an external register file.
//
// Handshake: enq and deq are levels; each rising edge is one request.  A
// request is either accepted at the clock edge that sees the pulse or it is
// dropped (enq while full without a deq, deq while empty).  There is no
// back-pressure; the requester watches full/empty.
module queue_lcu
    import queue_lcu_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enq,
    input  logic             deq,
    input  logic [DW-1:0]    in,
    output logic [DW-1:0]    out,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] valid,
    output logic [AW-1:0]    ra,
    input  logic [DW-1:0]    rd,
    output logic [AW-1:0]    wa,
    output logic [DW-1:0]    wd,
    output logic             we
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic             enq_p;
    logic             deq_p;
    logic             acc_enq;
    logic             acc_deq;
    logic             bypass;

    logic [PTR_W-1:0] head_q,  head_d;
    logic [PTR_W-1:0] tail_q,  tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DW-1:0]    out_q,   out_d;
    logic [AW-1:0]    wa_q,    wa_d;
    logic [DW-1:0]    wd_q,    wd_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    lcu_state_e       state_q, state_d;

    edge_pulse u_enq_edge (
        .clk     (clk),
        .rstn    (rstn),
        .d_i     (enq),
        .pulse_o (enq_p)
    );

    edge_pulse u_deq_edge (
        .clk     (clk),
        .rstn    (rstn),
        .d_i     (deq),
        .pulse_o (deq_p)
    );

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign acc_deq = deq_p & ~empty;
    // A dequeue at the same edge frees the slot, so a full queue still
    // takes the write.
    assign acc_enq = enq_p & (~full | acc_deq);

    // The RF commits a write one edge after we; if the entry being read is
    // that uncommitted write, take the data from wd instead of rd.
    assign bypass  = we & (wa_q == ra);

    assign ra    = AW'(head_q);
    assign out   = out_q;
    assign wa    = wa_q;
    assign wd    = wd_q;
    assign we    = (state_q == ST_WRITE);
    assign valid = valid_q;

    // Next-state: pointers, count, valid bits, output word and write port.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        out_d   = out_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        valid_d = valid_q;
        state_d = ST_IDLE;

        // Clear before set: when full with both accepted, head == tail and
        // the slot must end up valid again.
        if (acc_deq) begin
            out_d           = bypass ? wd_q : rd;
            head_d          = head_q + PTR_W'(1);
            valid_d[head_q] = 1'b0;
        end

        if (acc_enq) begin
            wa_d            = AW'(tail_q);
            wd_d            = in;
            tail_d          = tail_q + PTR_W'(1);
            valid_d[tail_q] = 1'b1;
            state_d         = ST_WRITE;
        end

        case ({acc_enq, acc_deq})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops any write in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            out_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            valid_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            out_q   <= out_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_queue_lcu.sv
// Directed bench for queue_lcu with a behavioural RF and a scoreboard of
// expected dequeued words.
module tb_queue_lcu;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             rstn;
    logic             enq;
    logic             deq;
    logic [DW-1:0]    in_d;
    logic [DW-1:0]    out;
    logic             full;
    logic             empty;
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    ra;
    logic [DW-1:0]    rd;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic             we;

    // Register file: synchronous write, combinational read.
    logic [DW-1:0] rf [32];
    always @(posedge clk) if (we) rf[wa] <= wd;
    assign rd = rf[ra];

    // Reference state.
    logic [DW-1:0]    exp_q[$];
    int               m_head;
    int               m_tail;
    int               m_count;
    logic [DW-1:0]    m_last;
    logic [DEPTH-1:0] m_valid;

    int n_assert;
    int n_fail;

    queue_lcu #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .enq   (enq),
        .deq   (deq),
        .in    (in_d),
        .out   (out),
        .full  (full),
        .empty (empty),
        .valid (valid),
        .ra    (ra),
        .rd    (rd),
        .wa    (wa),
        .wd    (wd),
        .we    (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_head  = 0;
        m_tail  = 0;
        m_count = 0;
        m_last  = '0;
        m_valid = '0;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_we"},    32'(we),    32'd0);
        check({tag, "_wa"},    32'(wa),    32'd0);
        check({tag, "_wd"},    wd,         32'd0);
        check({tag, "_out"},   out,        32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"},  32'(full),  32'd0);
        check({tag, "_ra"},    32'(ra),    32'd0);
    endtask

    // Reset, ending at a negedge with requests low.
    task automatic do_reset(input string tag);
        enq  = 1'b0;
        deq  = 1'b0;
        in_d = '0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_idle_state(tag);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    // One request cycle, entered and left at a negedge.  Requests drop at
    // the end, so consecutive steps give a fresh edge only when the same
    // request is not repeated; use idle() in between for that.
    task automatic step(input string tag, input logic e, input logic d, input logic [31:0] data);
        logic dacc;
        logic eacc;
        dacc = d && (m_count != 0);
        eacc = e && ((m_count != DEPTH) || dacc);
        enq  = e;
        deq  = d;
        in_d = data;
        @(negedge clk);
        if (dacc) begin
            m_last = exp_q.pop_front();
            m_valid[m_head] = 1'b0;
            m_head = (m_head + 1) % DEPTH;
        end
        if (eacc) begin
            check({tag, "_wa"}, 32'(wa), 32'(m_tail));
            check({tag, "_wd"}, wd, data);
            exp_q.push_back(data);
            m_valid[m_tail] = 1'b1;
            m_tail = (m_tail + 1) % DEPTH;
        end
        if (eacc && !dacc) m_count++;
        if (dacc && !eacc) m_count--;
        check({tag, "_we"},    32'(we),    32'(eacc));
        check({tag, "_out"},   out,        m_last);
        check({tag, "_full"},  32'(full),  32'(m_count == DEPTH));
        check({tag, "_empty"}, 32'(empty), 32'(m_count == 0));
        check({tag, "_valid"}, 32'(valid), 32'(m_valid));
        enq = 1'b0;
        deq = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [31:0] data);
        step(tag, 1'b1, 1'b0, data);
        idle();
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b0, 1'b1, 32'd0);
        idle();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rstn = 1'b1;
        enq  = 1'b0;
        deq  = 1'b0;
        in_d = '0;
        model_clear();

        // Reset state and first enqueue.
        do_reset("rst");
        push("enq11", 32'h11);
        check("enq11_valid_after", 32'(valid), 32'h01);
        check("enq11_empty_after", 32'(empty), 32'd0);

        // Fill, overflow request, drain, underflow request.
        do_reset("rst_fill");
        for (int i = 1; i <= 8; i++) push("fill", 32'(i));
        push("ovf", 32'hFF);
        check("ovf_valid", 32'(valid), 32'hFF);
        check("ovf_tail", 32'(m_tail), 32'd0);
        for (int i = 0; i < 8; i++) pop("drain");
        check("drain_last", out, 32'h08);
        pop("udf");
        check("udf_out", out, 32'h08);
        check("udf_empty", 32'(empty), 32'd1);

        // Wrap-around.
        do_reset("rst_wrap");
        for (int i = 0; i < 6; i++) push("w_enq", 32'h30 + 32'(i));
        for (int i = 0; i < 6; i++) pop("w_deq");
        for (int i = 0; i < 4; i++) push("w_enqa", 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) pop("w_deqa");
        check("wrap_out", out, 32'hA3);

        // Bypass: dequeue the cycle after enqueuing into an empty queue.
        do_reset("rst_byp");
        step("byp_enq", 1'b1, 1'b0, 32'h5A);
        step("byp_deq", 1'b0, 1'b1, 32'd0);
        idle();
        check("byp_out", out, 32'h5A);
        check("byp_empty", 32'(empty), 32'd1);

        // Simultaneous enq/deq while full.
        do_reset("rst_sim");
        for (int i = 1; i <= 8; i++) push("s_fill", 32'(i));
        step("sim", 1'b1, 1'b1, 32'h99);
        check("sim_out", out, 32'h01);
        check("sim_wa", 32'(wa), 32'd0);
        check("sim_full", 32'(full), 32'd1);
        idle();
        for (int i = 0; i < 8; i++) pop("s_drain");
        check("sim_last", out, 32'h99);

        // Simultaneous enq/deq while empty: deq ignored.
        do_reset("rst_se");
        step("se", 1'b1, 1'b1, 32'h42);
        idle();
        pop("se_deq");
        check("se_out", out, 32'h42);

        // Reset mid-write drops the pulse; enq held through release is no edge.
        do_reset("rst_mid");
        step("mid_enq", 1'b1, 1'b0, 32'h77);
        rstn = 1'b0;
        #1;
        check_idle_state("mid_rst");
        enq = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("held_we0", 32'(we), 32'd0);
        @(negedge clk);
        check("held_we1", 32'(we), 32'd0);
        check("held_empty", 32'(empty), 32'd1);
        enq = 1'b0;
        @(negedge clk);
        model_clear();
        push("post_held", 32'h66);
        pop("post_held_deq");

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
